// File: rtl/i2c_master_ctrl.sv
// Single-master I2C initiator for 7-bit serial memories with 16-bit internal addressing.
// One command at a time: a single-byte write, or a single-byte random read that uses a
// repeated start. SCL/SDA are open-drain enables; slave clock stretching is honoured.
//
// Ports:
//   clk, rstn              system clock, asynchronous active-low reset
//   cmd_valid              command request, accepted only while idle
//   cmd_read               1 = read, 0 = write
//   cmd_dev/maddr/wdata    device address, memory address (MSB byte first), write byte
//   busy, done             transaction in progress, one-cycle completion pulse
//   ack_err                slave NACK seen in the last transaction (held until next accept)
//   rdata                  read byte, updated only on a successful read
//   scl_i, sda_i           pad inputs
//   scl_oe, sda_oe         1 = pull the line low
module i2c_master_ctrl #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    input  logic        cmd_read,
    input  logic [6:0]  cmd_dev,
    input  logic [15:0] cmd_maddr,
    input  logic [7:0]  cmd_wdata,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic [7:0]  rdata,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        scl_oe,
    output logic        sda_oe
);

    localparam logic [9:0] QMax = 10'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        StIdle, StStart, StDevW, StAckDw, StMadH, StAckH, StMadL, StAckL,
        StWdat, StAckWd, StRstart, StDevR, StAckDr, StRdat, StMnack, StStop
    } state_e;

    state_e      state_q, state_d;
    logic [9:0]  qcnt_q, qcnt_d;
    logic [1:0]  quar_q, quar_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  rx_q, rx_d;
    logic        nack_q, nack_d;
    logic        ack_err_q, ack_err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        sda_q, sda_d;

    logic        read_q;
    logic [6:0]  dev_q;
    logic [15:0] maddr_q;
    logic [7:0]  wdata_q;

    logic        stall, qtick, btick, sample;
    logic        is_tx, is_ack;
    logic [7:0]  txbyte;

    // Slave stretching: the quarter counter freezes in Q2 while the line is held low.
    assign stall  = (quar_q == 2'd2) && !scl_i;
    assign qtick  = !stall && (qcnt_q == QMax);
    assign btick  = qtick && (quar_q == 2'd3);
    assign sample = qtick && (quar_q == 2'd2);

    always_comb begin
        is_tx  = 1'b0;
        is_ack = 1'b0;
        txbyte = 8'h00;
        case (state_q)
            StDevW:  begin is_tx = 1'b1; txbyte = {dev_q, 1'b0}; end
            StMadH:  begin is_tx = 1'b1; txbyte = maddr_q[15:8]; end
            StMadL:  begin is_tx = 1'b1; txbyte = maddr_q[7:0]; end
            StWdat:  begin is_tx = 1'b1; txbyte = wdata_q; end
            StDevR:  begin is_tx = 1'b1; txbyte = {dev_q, 1'b1}; end
            StAckDw, StAckH, StAckL, StAckWd, StAckDr: is_ack = 1'b1;
            default: ;
        endcase
    end

    // Line drive per quarter. SDA goes through a register so it always moves one cycle
    // after the SCL edge of the same quarter, keeping data changes inside SCL-low.
    always_comb begin
        scl_oe = 1'b0;
        sda_d  = 1'b0;
        case (state_q)
            StIdle: ;
            StStart, StRstart: begin
                scl_oe = (quar_q == 2'd0) || (quar_q == 2'd3);
                sda_d  = quar_q[1];
            end
            StStop: begin
                scl_oe = (quar_q == 2'd0);
                sda_d  = !quar_q[1];
            end
            default: begin
                scl_oe = !quar_q[1];
                sda_d  = is_tx ? !txbyte[bit_q] : 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        quar_d    = quar_q;
        bit_d     = bit_q;
        rx_d      = rx_q;
        nack_d    = nack_q;
        ack_err_d = ack_err_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        if (state_q == StIdle) begin
            qcnt_d = '0;
            quar_d = 2'd0;
            bit_d  = 3'd7;
            if (cmd_valid) begin
                state_d   = StStart;
                ack_err_d = 1'b0;
            end
        end else begin
            if (!stall) begin
                qcnt_d = (qcnt_q == QMax) ? '0 : qcnt_q + 10'd1;
            end
            if (qtick) begin
                quar_d = quar_q + 2'd1;
            end
            if (sample) begin
                nack_d = sda_i;
                if (state_q == StRdat) begin
                    rx_d = {rx_q[6:0], sda_i};
                end
            end
            if (btick) begin
                bit_d = 3'd7;
                if ((is_tx || state_q == StRdat) && bit_q != 3'd0) begin
                    bit_d = bit_q - 3'd1;
                end else begin
                    unique case (state_q)
                        StStart:  state_d = StDevW;
                        StDevW:   state_d = StAckDw;
                        StAckDw:  state_d = nack_q ? StStop : StMadH;
                        StMadH:   state_d = StAckH;
                        StAckH:   state_d = nack_q ? StStop : StMadL;
                        StMadL:   state_d = StAckL;
                        StAckL:   state_d = nack_q ? StStop : (read_q ? StRstart : StWdat);
                        StWdat:   state_d = StAckWd;
                        StAckWd:  state_d = StStop;
                        StRstart: state_d = StDevR;
                        StDevR:   state_d = StAckDr;
                        StAckDr:  state_d = nack_q ? StStop : StRdat;
                        StRdat:   state_d = StMnack;
                        StMnack: begin
                            state_d = StStop;
                            rdata_d = rx_q;
                        end
                        StStop: begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                        default:  state_d = StIdle;
                    endcase
                    if (is_ack && nack_q) begin
                        ack_err_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            qcnt_q    <= '0;
            quar_q    <= 2'd0;
            bit_q     <= 3'd7;
            rx_q      <= 8'h00;
            nack_q    <= 1'b0;
            ack_err_q <= 1'b0;
            rdata_q   <= 8'h00;
            done_q    <= 1'b0;
            sda_q     <= 1'b0;
            read_q    <= 1'b0;
            dev_q     <= 7'h00;
            maddr_q   <= 16'h0000;
            wdata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            quar_q    <= quar_d;
            bit_q     <= bit_d;
            rx_q      <= rx_d;
            nack_q    <= nack_d;
            ack_err_q <= ack_err_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            sda_q     <= sda_d;
            if (state_q == StIdle && cmd_valid) begin
                read_q  <= cmd_read;
                dev_q   <= cmd_dev;
                maddr_q <= cmd_maddr;
                wdata_q <= cmd_wdata;
            end
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;
    assign sda_oe  = sda_q;

endmodule
